jp_dev: RTL and testbench

- Device-side model of a standard NES joypad: the responder end of the joypad serial protocol.
- Samples `jp_latch_in` / `jp_clk_in` driven by a host joypad controller and shifts out 8 button states on `jp_data_out`, matching a 4021-based pad.
- Used to drive the host controller in simulation and board loopback, and to feed virtual-button sources (debugger, UART) onto a real joypad port.
- Includes input synchronisation, glitch filtering and optional A/B turbo.

---
 rtl/jp_dev.sv | 189 ++++++++++++++++++
 tb/tb_jp_dev.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jp_dev.sv
`timescale 1ns/1ps
// jp_dev - device (responder) side of the NES joypad serial protocol.
//
// Behaves like a 4021-based pad. While the host holds latch high, the
// current button state is parallel-loaded (active-low). Each host clock
// rising edge then shifts the register right by one bit. The line always
// presents bit 0 of the shift register. A and B can be modulated by a
// free-running turbo square wave.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   btn_in[7:0]    live buttons, 1 = pressed
//                  ([0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right)
//   turbo_en_in    [0] turbo on A, [1] turbo on B
//   jp_latch_in    host latch, asynchronous to clk
//   jp_clk_in      host shift clock, asynchronous to clk
//   jp_data_out    serial data, active-low (0 = pressed)
//   shift_cnt_out  bits shifted since the last latch fall, saturates at 8
//   poll_out       one-cycle pulse per accepted latch falling edge
module jp_dev #(
    parameter int   FILT_CYCLES = 4,
    parameter int   TURBO_DIV   = 833333,
    parameter logic FILL_BIT    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn_in,
    input  logic [1:0] turbo_en_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    output logic       jp_data_out,
    output logic [3:0] shift_cnt_out,
    output logic       poll_out
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Pin index 0 = latch, 1 = clock
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_s;
    logic [1:0] filt_dly_q;
    logic       latch_rise_s, latch_fall_s, clk_rise_s;

    logic [TW-1:0] turbo_cnt_q;
    logic          phase_q;
    logic          eff_a_s, eff_b_s;
    logic [7:0]    load_val_s;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       poll_q, poll_d;

    // Two-flop synchronisers for both host pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {jp_clk_in, jp_latch_in};
            sync2_q <= sync1_q;
        end
    end

    // Independent glitch filter per pin: the filtered level follows only
    // after the synced level has differed for FILT_CYCLES consecutive cycles.
    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [FW-1:0] cnt_q;
        logic          filt_q;

        // Disagreement counter and filtered level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync2_q[g] != filt_q) begin
                if (cnt_q == FILT_LAST) begin
                    filt_q <= sync2_q[g];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign filt_s[g] = filt_q;
    end

    // One-cycle delayed filtered levels for edge strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_dly_q <= 2'b00;
        end else begin
            filt_dly_q <= filt_s;
        end
    end

    assign latch_rise_s = filt_s[0] & ~filt_dly_q[0];
    assign latch_fall_s = ~filt_s[0] & filt_dly_q[0];
    assign clk_rise_s   = filt_s[1] & ~filt_dly_q[1];

    // Turbo divider: phase toggles each time the counter wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turbo_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (turbo_cnt_q == TURBO_LAST) begin
            turbo_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            turbo_cnt_q <= turbo_cnt_q + 1'b1;
        end
    end

    // A turbo-enabled button only reads as pressed during phase 1
    assign eff_a_s    = btn_in[0] & (~turbo_en_in[0] | phase_q);
    assign eff_b_s    = btn_in[1] & (~turbo_en_in[1] | phase_q);
    assign load_val_s = ~{btn_in[7:2], eff_b_s, eff_a_s};

    // Protocol FSM: next state, shift register, counter and poll strobe
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        poll_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                // Keep loading through the fall cycle so the frozen value is
                // the one seen at the latch fall; clock edges are ignored here.
                shift_d = load_val_s;
                cnt_d   = 4'd0;
                if (latch_fall_s) begin
                    state_d = ST_SHIFT;
                    poll_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_IDLE, ST_SHIFT: begin
                // Latch rise takes priority over a coincident clock rise
                if (latch_rise_s) begin
                    state_d = ST_LOAD;
                end else if (clk_rise_s) begin
                    shift_d = {FILL_BIT, shift_q[7:1]};
                    cnt_d   = (cnt_q == 4'd8) ? 4'd8 : (cnt_q + 4'd1);
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = 8'hFF;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= 8'hFF;
            cnt_q   <= 4'd0;
            poll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
        end
    end

    assign jp_data_out   = shift_q[0];
    assign shift_cnt_out = cnt_q;
    assign poll_out      = poll_q;

endmodule

// File: tb/tb_jp_dev.sv
`timescale 1ns/1ps
// Scoreboard bench for jp_dev: stimulus pushes expected observations,
// a negedge monitor pops and compares on poll_out pulses and check requests.
module tb_jp_dev;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_in;
    logic [1:0] turbo_en_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic       jp_data_out;
    logic [3:0] shift_cnt_out;
    logic       poll_out;

    typedef struct packed {
        logic       is_poll;
        logic       data;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    logic chk_req = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tcyc;

    jp_dev #(
        .FILT_CYCLES(4),
        .TURBO_DIV  (10),
        .FILL_BIT   (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .turbo_en_in  (turbo_en_in),
        .jp_latch_in  (jp_latch_in),
        .jp_clk_in    (jp_clk_in),
        .jp_data_out  (jp_data_out),
        .shift_cnt_out(shift_cnt_out),
        .poll_out     (poll_out)
    );

    always #10 clk = ~clk;

    // Reference cycle count since reset release, used to predict turbo phase
    always @(posedge clk or posedge rst) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (poll_out === 1'b1) begin
            if (sb_q.size() == 0 || !sb_q[0].is_poll) begin
                n_cmp++;
                n_bad++;
                $display("FAIL poll_unexpected: poll_out=1 expected 0 (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                cmp("poll_first_bit", {3'b000, jp_data_out}, {3'b000, e.data});
                cmp("poll_cnt", shift_cnt_out, e.cnt);
            end
        end
        if (chk_req) begin
            if (sb_q.size() == 0 || sb_q[0].is_poll) begin
                n_cmp++;
                n_bad++;
                $display("FAIL chk_order: got no check entry expected one (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                cmp("data", {3'b000, jp_data_out}, {3'b000, e.data});
                cmp("cnt", shift_cnt_out, e.cnt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_chk(input logic d, input logic [3:0] c);
        exp_t e;
        e.is_poll = 1'b0;
        e.data    = d;
        e.cnt     = c;
        sb_q.push_back(e);
        chk_req = 1'b1;
        tick(1);
        chk_req = 1'b0;
    endtask

    // One host clock pulse: 10 cycles high, 10 low; check after the shift lands
    task automatic clk_pulse(input logic d, input logic [3:0] c);
        jp_clk_in = 1'b1;
        tick(9);
        expect_chk(d, c);
        jp_clk_in = 1'b0;
        tick(10);
    endtask

    // Latch pulse; optionally hold the fall until the load lands mid turbo phase
    task automatic latch_frame(input logic first_bit, input bit align, input int want);
        exp_t e;
        bit   found;
        jp_latch_in = 1'b1;
        tick(12);
        if (align) begin
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if ((tcyc % 10) == 9 && (((tcyc + 6) / 10) % 2) == want) found = 1'b1;
                else tick(1);
            end
            n_cmp++;
            if (!found) begin
                n_bad++;
                $display("FAIL turbo_align: got no aligned slot expected phase %0d", want);
            end
        end
        e.is_poll = 1'b1;
        e.data    = first_bit;
        e.cnt     = 4'd0;
        sb_q.push_back(e);
        jp_latch_in = 1'b0;
        tick(12);
    endtask

    logic [7:0] f1_bits;
    logic [7:0] f3_bits;

    initial begin
        rst         = 1'b1;
        btn_in      = 8'h00;
        turbo_en_in = 2'b00;
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b0;
        tick(3);
        // Reset state, then quiet line for 100 cycles
        expect_chk(1'b1, 4'd0);
        rst = 1'b0;
        tick(100);
        expect_chk(1'b1, 4'd0);

        // Frame 1: A + Right -> register 0111_1110
        btn_in  = 8'b1000_0001;
        f1_bits = 8'b0111_1110;
        latch_frame(1'b0, 1'b0, 0);
        for (int k = 1; k <= 8; k++) begin
            clk_pulse((k <= 7) ? f1_bits[k] : 1'b0, 4'(k));
        end
        // Past eight clocks: fill level, count held
        for (int k = 0; k < 4; k++) clk_pulse(1'b0, 4'd8);

        // Frame 2: 0011_1100 -> register 1100_0011
        btn_in = 8'h3C;
        latch_frame(1'b1, 1'b0, 0);
        clk_pulse(1'b1, 4'd1);
        clk_pulse(1'b0, 4'd2);
        clk_pulse(1'b0, 4'd3);
        // Short clock glitch: no shift
        jp_clk_in = 1'b1;
        tick(2);
        jp_clk_in = 1'b0;
        tick(12);
        expect_chk(1'b0, 4'd3);
        // Buttons change mid-shift and a short latch glitch: no reload, no poll
        btn_in      = 8'h00;
        jp_latch_in = 1'b1;
        tick(3);
        jp_latch_in = 1'b0;
        tick(12);
        expect_chk(1'b0, 4'd3);
        clk_pulse(1'b0, 4'd4);
        clk_pulse(1'b0, 4'd5);

        // Turbo on A: released in phase 0, pressed in phase 1
        btn_in      = 8'h01;
        turbo_en_in = 2'b01;
        latch_frame(1'b1, 1'b1, 0);
        latch_frame(1'b0, 1'b1, 1);
        turbo_en_in = 2'b00;

        // Reset mid-shift: register 1010_0101
        btn_in  = 8'h5A;
        f3_bits = 8'b1010_0101;
        latch_frame(1'b1, 1'b0, 0);
        clk_pulse(1'b0, 4'd1);
        clk_pulse(1'b1, 4'd2);
        clk_pulse(1'b0, 4'd3);
        rst = 1'b1;
        expect_chk(1'b1, 4'd0);
        rst = 1'b0;
        tick(5);
        latch_frame(1'b1, 1'b0, 0);
        for (int k = 1; k <= 8; k++) begin
            clk_pulse((k <= 7) ? f3_bits[k] : 1'b0, 4'(k));
        end

        tick(5);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
